// File: rtl/wb_master_pkg.sv
// wb_master_pkg: shared FSM state type and Wishbone cycle-type constants
package wb_master_pkg;
  typedef enum logic [1:0] {IDLE, STALL, XFER} state_t;
  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_INCR = 3'b010;
  localparam logic [2:0] CTI_EOB = 3'b111;
endpackage

// File: rtl/wb_timeout_cnt.sv
// wb_timeout_cnt: counts enabled cycles, expired flags the TIMEOUT-th one
// ports: clk, rst (async), clear (sync zero), enable (count this cycle), expired
module wb_timeout_cnt #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);
  localparam int W = $clog2(TIMEOUT + 1);
  logic [W-1:0] cnt;
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt <= '0;
    else if (clear) cnt <= '0;
    else if (enable) cnt <= cnt + 1'b1;
  assign expired = enable && cnt == W'(TIMEOUT - 1);
endmodule

// File: rtl/wb_burst_master.sv
// wb_burst_master: command-driven incrementing Wishbone burst master with ack timeout
// ports: cmd_* command in, wdata_* write beats in, rdata_* read beats out,
// done/err completion pulses, wb_* Wishbone master bus
module wb_burst_master
  import wb_master_pkg::*;
#(
  parameter int DW = 32,
  parameter int AW = 26,
  parameter int BL = 5,
  parameter int TIMEOUT = 255
) (
  input  logic          sys_clk,
  input  logic          RESET,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic          cmd_we,
  input  logic [AW-1:0] cmd_addr,
  input  logic [BL-1:0] cmd_len,
  input  logic [DW/8-1:0] cmd_sel,
  input  logic          wdata_valid,
  output logic          wdata_ready,
  input  logic [DW-1:0] wdata,
  output logic          rdata_valid,
  output logic [DW-1:0] rdata,
  output logic          rdata_last,
  output logic          done,
  output logic          err,
  output logic          wb_cyc_o,
  output logic          wb_stb_o,
  output logic          wb_we_o,
  output logic [AW-1:0] wb_addr_o,
  output logic [DW-1:0] wb_dat_o,
  output logic [DW/8-1:0] wb_sel_o,
  output logic [2:0]    wb_cti_o,
  input  logic          wb_ack_i,
  input  logic [DW-1:0] wb_dat_i
);
  state_t state, nxt;
  logic [BL-1:0] cnt;
  logic multi, ack, last, accept, load, expired;
  wb_timeout_cnt #(.TIMEOUT(TIMEOUT)) u_tmo (
    .clk(sys_clk),
    .rst(RESET),
    .clear(state != XFER || wb_ack_i),
    .enable(state == XFER && !wb_ack_i),
    .expired(expired)
  );
  // cmd_ready is gated by RESET so it reads 0 while reset is held
  always_comb begin
    nxt = state;
    cmd_ready = state == IDLE && !RESET;
    accept = cmd_ready && cmd_valid;
    ack = wb_ack_i && state == XFER;
    last = cnt == BL'(1);
    wdata_ready = state == STALL || (ack && wb_we_o && !last);
    load = wdata_ready && wdata_valid;
    wb_cyc_o = state != IDLE;
    wb_stb_o = state == XFER;
    wb_cti_o = (state == IDLE || !multi) ? CTI_CLASSIC : last ? CTI_EOB : CTI_INCR;
    if (accept) nxt = cmd_we ? STALL : XFER;
    else if (state == STALL && wdata_valid) nxt = XFER;
    else if (ack) nxt = last ? IDLE : (wb_we_o && !wdata_valid) ? STALL : XFER;
    else if (expired) nxt = IDLE;
  end
  always_ff @(posedge sys_clk or posedge RESET)
    if (RESET) state <= IDLE;
    else state <= nxt;
  always_ff @(posedge sys_clk or posedge RESET)
    if (RESET) begin
      cnt <= '0;
      multi <= 1'b0;
      wb_we_o <= 1'b0;
      wb_addr_o <= '0;
      wb_sel_o <= '0;
      wb_dat_o <= '0;
      rdata <= '0;
      rdata_valid <= 1'b0;
      rdata_last <= 1'b0;
      done <= 1'b0;
      err <= 1'b0;
    end else begin
      rdata_valid <= ack && !wb_we_o;
      rdata_last <= ack && !wb_we_o && last;
      done <= ack && last;
      err <= expired;
      if (ack && !wb_we_o) rdata <= wb_dat_i;
      if (load) wb_dat_o <= wdata;
      if (accept) begin
        wb_addr_o <= cmd_addr;
        wb_we_o <= cmd_we;
        wb_sel_o <= cmd_sel;
        cnt <= cmd_len == '0 ? BL'(1) : cmd_len;
        multi <= cmd_len > BL'(1);
      end else if (ack) begin
        wb_addr_o <= wb_addr_o + AW'(DW / 8);
        cnt <= cnt - 1'b1;
      end
    end
endmodule

// File: tb/tb_wb_burst_master.sv
// tb_wb_burst_master: directed checks of wb_burst_master against a small Wishbone slave
module tb_wb_burst_master;
  localparam int AW = 26;
  localparam int BL = 5;
  logic sys_clk = 1'b0;
  logic RESET = 1'b1;
  logic cmd_valid = 1'b0, cmd_we = 1'b0;
  logic [AW-1:0] cmd_addr = '0;
  logic [BL-1:0] cmd_len = '0;
  logic [3:0] cmd_sel = '0;
  logic cmd_ready, wdata_valid, wdata_ready, rdata_valid, rdata_last, done, err;
  logic [31:0] wdata, rdata, wb_dat_o, wb_dat_i;
  logic wb_cyc_o, wb_stb_o, wb_we_o, wb_ack_i;
  logic [AW-1:0] wb_addr_o;
  logic [3:0] wb_sel_o;
  logic [2:0] wb_cti_o;
  int vectors = 0, miscompares = 0;
  int cy = 0, n_done = 0, n_err = 0, n_acc = 0, n_stb = 0, done_cy = 0, ack_cy = 0;
  int widx = 0, wlimit = 0, wcnt = 0, ack_lat = 0;
  int b_done, b_err, b_acc, b_stb, b_a, b_r, w0;
  logic ack_en = 1'b1;
  logic [31:0] wq [16];
  logic [AW-1:0] a_addr [$];
  logic [31:0] a_dat [$];
  logic [2:0] a_cti [$];
  logic [31:0] r_dat [$];
  logic r_last [$];

  wb_burst_master #(.TIMEOUT(8)) dut (
    .sys_clk(sys_clk), .RESET(RESET),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_sel(cmd_sel),
    .wdata_valid(wdata_valid), .wdata_ready(wdata_ready), .wdata(wdata),
    .rdata_valid(rdata_valid), .rdata(rdata), .rdata_last(rdata_last),
    .done(done), .err(err),
    .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o),
    .wb_addr_o(wb_addr_o), .wb_dat_o(wb_dat_o), .wb_sel_o(wb_sel_o),
    .wb_cti_o(wb_cti_o), .wb_ack_i(wb_ack_i), .wb_dat_i(wb_dat_i)
  );

  always #5 sys_clk = ~sys_clk;

  assign wb_ack_i = ack_en && wb_stb_o && wcnt >= ack_lat;
  assign wb_dat_i = 32'hD000_0000 | 32'(wb_addr_o);
  assign wdata_valid = widx < wlimit;
  assign wdata = wq[widx[3:0]];

  always @(posedge sys_clk) begin
    wcnt <= (wb_stb_o && !wb_ack_i) ? wcnt + 1 : 0;
    if (wdata_valid && wdata_ready) widx <= widx + 1;
    if (wb_stb_o && wb_ack_i) begin
      a_addr.push_back(wb_addr_o);
      a_dat.push_back(wb_dat_o);
      a_cti.push_back(wb_cti_o);
      ack_cy = cy;
    end
    if (wb_stb_o) n_stb++;
    if (rdata_valid) begin
      r_dat.push_back(rdata);
      r_last.push_back(rdata_last);
    end
    if (done) begin
      n_done++;
      done_cy = cy;
    end
    if (err) n_err++;
    if (cmd_valid && cmd_ready) n_acc++;
    cy++;
  end

  task automatic tick;
    @(posedge sys_clk);
    #2;
  endtask

  task automatic base;
    b_done = n_done; b_err = n_err; b_acc = n_acc; b_stb = n_stb;
    b_a = a_addr.size(); b_r = r_dat.size(); w0 = widx;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic we, input logic [AW-1:0] addr, input logic [BL-1:0] len);
    cmd_we = we; cmd_addr = addr; cmd_len = len; cmd_sel = 4'hF; cmd_valid = 1'b1;
  endtask

  initial begin
    #1;
    chk("rst_cmd_ready", cmd_ready, 0);
    chk("rst_cyc", wb_cyc_o, 0);
    chk("rst_done", done, 0);
    repeat (2) tick;
    RESET = 1'b0;
    #1;
    chk("post_rst_cmd_ready", cmd_ready, 1);
    // single-beat read, ack after two wait cycles
    base; ack_lat = 2;
    issue(1'b0, 26'h100, 5'd1);
    #1;
    chk("t1_ready", cmd_ready, 1);
    tick; cmd_valid = 1'b0;
    chk("t1_stb", wb_stb_o, 1);
    chk("t1_cti", wb_cti_o, 3'b000);
    chk("t1_addr", wb_addr_o, 26'h100);
    chk("t1_we", wb_we_o, 0);
    repeat (8) tick;
    chk("t1_stb_cycles", n_stb - b_stb, 3);
    chk("t1_acks", a_addr.size() - b_a, 1);
    chk("t1_ack_cti", a_cti[b_a], 3'b000);
    chk("t1_beats", r_dat.size() - b_r, 1);
    chk("t1_rdata", r_dat[b_r], 32'hD000_0100);
    chk("t1_rlast", r_last[b_r], 1);
    chk("t1_done", n_done - b_done, 1);
    chk("t1_done_lat", done_cy - ack_cy, 1);
    // three-beat write wrapping the address space
    base; ack_lat = 0;
    wq[w0] = 32'hAAAA_0001; wq[w0 + 1] = 32'hBBBB_0002; wq[w0 + 2] = 32'hCCCC_0003;
    wlimit = w0 + 3;
    issue(1'b1, 26'h3FF_FFFC, 5'd3);
    tick; cmd_valid = 1'b0;
    chk("t2_stall_cyc", wb_cyc_o, 1);
    chk("t2_stall_stb", wb_stb_o, 0);
    repeat (8) tick;
    chk("t2_acks", a_addr.size() - b_a, 3);
    chk("t2_addr0", a_addr[b_a], 26'h3FF_FFFC);
    chk("t2_addr1", a_addr[b_a + 1], 26'h000_0000);
    chk("t2_addr2", a_addr[b_a + 2], 26'h000_0004);
    chk("t2_dat0", a_dat[b_a], 32'hAAAA_0001);
    chk("t2_dat1", a_dat[b_a + 1], 32'hBBBB_0002);
    chk("t2_dat2", a_dat[b_a + 2], 32'hCCCC_0003);
    chk("t2_cti0", a_cti[b_a], 3'b010);
    chk("t2_cti1", a_cti[b_a + 1], 3'b010);
    chk("t2_cti2", a_cti[b_a + 2], 3'b111);
    chk("t2_done", n_done - b_done, 1);
    chk("t2_done_lat", done_cy - ack_cy, 1);
    chk("t2_consumed", widx - w0, 3);
    // four-beat write with data withheld for three cycles after beat 2
    base;
    wq[w0] = 32'h1111_0000; wq[w0 + 1] = 32'h2222_0000;
    wq[w0 + 2] = 32'h3333_0000; wq[w0 + 3] = 32'h4444_0000;
    wlimit = w0 + 2;
    issue(1'b1, 26'h200, 5'd4);
    tick; cmd_valid = 1'b0;
    repeat (3) tick;
    for (int i = 0; i < 3; i++) begin
      chk("t3_hold_stb", wb_stb_o, 0);
      chk("t3_hold_cyc", wb_cyc_o, 1);
      chk("t3_hold_wready", wdata_ready, 1);
      if (i < 2) tick;
    end
    wlimit = w0 + 4;
    repeat (8) tick;
    chk("t3_acks", a_addr.size() - b_a, 4);
    chk("t3_addr2", a_addr[b_a + 2], 26'h208);
    chk("t3_addr3", a_addr[b_a + 3], 26'h20C);
    chk("t3_dat1", a_dat[b_a + 1], 32'h2222_0000);
    chk("t3_dat2", a_dat[b_a + 2], 32'h3333_0000);
    chk("t3_dat3", a_dat[b_a + 3], 32'h4444_0000);
    chk("t3_cti2", a_cti[b_a + 2], 3'b010);
    chk("t3_cti3", a_cti[b_a + 3], 3'b111);
    chk("t3_done", n_done - b_done, 1);
    // read with no ack: timeout after eight strobe cycles
    base; ack_en = 1'b0;
    issue(1'b0, 26'h300, 5'd2);
    tick; cmd_valid = 1'b0;
    chk("t4_stb", wb_stb_o, 1);
    repeat (7) tick;
    chk("t4_stb_late", wb_stb_o, 1);
    chk("t4_no_err_yet", err, 0);
    tick;
    chk("t4_cyc_drop", wb_cyc_o, 0);
    chk("t4_err", err, 1);
    chk("t4_ready", cmd_ready, 1);
    tick;
    chk("t4_err_pulse", err, 0);
    chk("t4_stb_cycles", n_stb - b_stb, 8);
    chk("t4_err_cnt", n_err - b_err, 1);
    chk("t4_no_done", n_done - b_done, 0);
    ack_en = 1'b1;
    // reset during beat 2 of an eight-beat read
    base;
    issue(1'b0, 26'h400, 5'd8);
    tick; cmd_valid = 1'b0;
    tick;
    chk("t5_beat2_addr", wb_addr_o, 26'h404);
    RESET = 1'b1;
    #1;
    chk("t5_cyc", wb_cyc_o, 0);
    chk("t5_stb", wb_stb_o, 0);
    chk("t5_we", wb_we_o, 0);
    chk("t5_addr", wb_addr_o, 0);
    chk("t5_dat", wb_dat_o, 0);
    chk("t5_sel", wb_sel_o, 0);
    chk("t5_cti", wb_cti_o, 0);
    chk("t5_rvalid", rdata_valid, 0);
    chk("t5_rdata", rdata, 0);
    chk("t5_ready", cmd_ready, 0);
    chk("t5_wready", wdata_ready, 0);
    repeat (2) tick;
    RESET = 1'b0;
    #1;
    chk("t5_ready_after", cmd_ready, 1);
    repeat (3) tick;
    chk("t5_no_done", n_done - b_done, 0);
    chk("t5_no_err", n_err - b_err, 0);
    base;
    issue(1'b0, 26'h500, 5'd1);
    tick; cmd_valid = 1'b0;
    repeat (5) tick;
    chk("t5_new_done", n_done - b_done, 1);
    chk("t5_new_rdata", r_dat[b_r], 32'hD000_0500);
    chk("t5_new_rlast", r_last[b_r], 1);
    // back-to-back reads with cmd_valid held high
    base;
    issue(1'b0, 26'h600, 5'd2);
    tick;
    tick;
    chk("t6_busy_ready", cmd_ready, 0);
    tick;
    chk("t6_gap_cyc", wb_cyc_o, 0);
    chk("t6_gap_ready", cmd_ready, 1);
    tick; cmd_valid = 1'b0;
    chk("t6_second_stb", wb_stb_o, 1);
    repeat (6) tick;
    chk("t6_accepts", n_acc - b_acc, 2);
    chk("t6_done", n_done - b_done, 2);
    chk("t6_beats", r_dat.size() - b_r, 4);
    chk("t6_rlast0", r_last[b_r + 1], 1);
    chk("t6_rlast1", r_last[b_r + 3], 1);
    chk("t6_rdata2", r_dat[b_r + 2], 32'hD000_0600);
    chk("t6_rdata3", r_dat[b_r + 3], 32'hD000_0604);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/wb_burst_master.md
WB_BURST_MASTER -- requirements
Module: wb_burst_master

Interface
REQ-001 SHALL use one clock and an asynchronous, active-high reset.
REQ-002 SHALL have parameter DW, default 32, Wishbone data width.
REQ-003 SHALL have parameter AW, default 26, Wishbone byte-address width.
REQ-004 SHALL have parameter BL, default 5, burst-length field width.
REQ-005 SHALL have parameter TIMEOUT, default 255, maximum cycles to wait for an ack.
REQ-006 SHALL have ports, in this order:
- sys_clk in 1: clock.
- RESET in 1: asynchronous, active-high reset.
- cmd_valid in 1 / cmd_ready out 1: command handshake.
- cmd_we in 1: 1 = write, 0 = read.
- cmd_addr in AW: start byte address.
- cmd_len in BL: beat count.
- cmd_sel in DW/8: byte enables for all beats.
- wdata_valid in 1 / wdata_ready out 1 / wdata in DW: write-beat handshake and data.
- rdata_valid out 1 / rdata out DW / rdata_last out 1: read beats, no backpressure.
- done out 1: burst-complete pulse.
- err out 1: timeout pulse.
- wb_cyc_o, wb_stb_o, wb_we_o out 1: Wishbone cycle, strobe and write enable, driving the SDRAM controller.
- wb_addr_o out AW: Wishbone byte address.
- wb_dat_o out DW: Wishbone write data.
- wb_sel_o out DW/8: Wishbone byte enables.
- wb_cti_o out 3: Wishbone cycle-type identifier.
- wb_ack_i in 1: Wishbone acknowledge.
- wb_dat_i in DW: Wishbone read data.

Function
REQ-007 SHALL use FSM states IDLE, STALL and XFER:
- IDLE: cyc = 0, stb = 0.
- STALL: cyc = 1, stb = 0; used only for writes.
- XFER: cyc = 1, stb = 1.
REQ-008 SHALL assert cmd_ready only in IDLE; on accept it SHALL latch addr, we, sel and the beat count. A cmd_len of 0 SHALL be treated as 1.
REQ-009 SHALL, on accept, go IDLE->XFER for a read (stb high the next cycle) and IDLE->STALL for a write.
REQ-010 SHALL assert wdata_ready in STALL, and in XFER during a write ack that is not the last beat.
- A wdata handshake SHALL load wb_dat_o and leave or stay in XFER.
- An ack with no wdata_valid present SHALL go XFER->STALL.
REQ-011 SHALL, on each ack, advance wb_addr_o by DW/8 modulo 2^AW and decrement the beat count.
REQ-012 SHALL hold wb_addr_o, wb_dat_o, wb_sel_o and wb_we_o stable while stb = 1 and ack = 0.
REQ-013 SHALL drive wb_cti_o as follows:
- Single-beat burst: 3'b000.
- Non-last beat of a multi-beat burst: 3'b010.
- Last beat: 3'b111.
REQ-014 SHALL present each read beat one cycle after its ack: rdata = registered wb_dat_i, with rdata_valid pulsed; rdata_last SHALL be set on the final beat.
REQ-015 SHALL, on the last ack, go to IDLE and pulse done the next cycle. cyc SHALL be low for at least one cycle between bursts, and a cmd_valid present at the last ack SHALL be accepted no earlier than the following cycle.
REQ-016 SHALL count cycles in XFER without an ack, clearing the count on each ack and on each entry to XFER.
- When the count reaches TIMEOUT: drop cyc/stb, go to IDLE and pulse err for one cycle; done SHALL NOT be pulsed.
- Outstanding write data SHALL NOT be consumed after the timeout.
REQ-017 SHALL ignore wb_ack_i while stb = 0.

Reset
REQ-018 SHALL, while RESET is asserted, asynchronously force IDLE and drive every output to 0, including cmd_ready; cmd_ready SHALL be 1 in the first cycle after RESET deasserts.
REQ-019 SHALL abandon any in-flight burst when RESET is asserted mid-burst, with no done or err pulse.

Structure
REQ-020 SHALL take the state enum and CTI constants CTI_CLASSIC/CTI_INCR/CTI_EOB from the shared package wb_master_pkg.
REQ-021 SHALL implement the timeout counter as the sub-module wb_timeout_cnt (inputs: clear, enable; output: expired).

Verification
REQ-022 Single read, addr 0x000100, len 1, ack after 2 cycles -> cti 000, one rdata_valid with rdata_last = 1, one done pulse.
REQ-023 Write, addr 0x3FFFFFC, len 3, data A/B/C, ack every cycle -> addresses 0x3FFFFFC, 0x0000000, 0x0000004; cti 010, 010, 111; done one cycle after the third ack.
REQ-024 Write, len 4, wdata_valid withheld 3 cycles after beat 2 -> stb low and cyc high for those 3 cycles, then beats 3-4 complete with the correct data.
REQ-025 Read, len 2, TIMEOUT = 8, no ack -> cyc drops after 8 cycles, one err pulse, no done, cmd_ready high the following cycle.
REQ-026 RESET asserted at beat 2 of a len-8 read -> all outputs 0 immediately, no done or err; a new len-1 read after reset completes normally.
REQ-027 Back-to-back commands with cmd_valid held high -> at least one idle cycle (cyc = 0) between bursts, and both bursts complete.
